video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised video timing generator; successor to the fixed counts block plus the
//  hand-written 1-cycle sync delay in the video top. Produces pixel counters for
//  fetch/LCD logic, sync/blank/de delayed by OUT_DELAY pixels to match RGB pipeline
//  latency, and gates RGB to black. Adds pixel clock enable, frame counter and frame pulse.
// PARAMETERS
//  H_ACTIVE 360  active pixels per line      | V_ACTIVE 360  active lines per frame
//  H_FP     16   h front porch (pixels)      | V_FP     4    v front porch (lines)
//  H_SYNC   8    hsync width (pixels)        | V_SYNC   2    vsync width (lines)
//  H_BP     136  h back porch (pixels)       | V_BP     159  v back porch (lines)
//  XW 10, YW 10  counter widths; must hold H/V totals - 1 (520/525 by default)
//  OUT_DELAY 1   alignment stages, 0..4, on sync/blank/de outputs
//  FRAME_W  8    frame counter width
// PORTS
//  clk_vid_32_768  in   1       video clock
//  reset           in   1       async, active-high
//  pix_en          in   1       pixel clock enable; all state advances only when high
//  blank_force     in   1       force rgb to black (core reset / no ROM)
//  rgb_in          in   24      pixel for counters OUT_DELAY enabled cycles earlier
//  video_x         out  XW      undelayed horizontal counter
//  video_y         out  YW      undelayed vertical counter
//  hsync/vsync     out  1 each  delayed, active-high
//  hblank/vblank   out  1 each  delayed, active-high
//  de              out  1       delayed, !hblank && !vblank
//  rgb             out  24      (blank_force || !de) ? 24'h0 : rgb_in; combinational
//  frame_count     out  FRAME_W completed frames, wraps mod 2^FRAME_W
//  frame_start     out  1       one-clk pulse when counters wrap to (0,0)
// BEHAVIOUR
//  Reset: video_x=0, video_y=0, every delay stage 0 (all sync/blank/de low),
//   frame_count=0, frame_start=0. First enabled cycle after reset presents (0,0).
//  Line layout: x 0..H_ACTIVE-1 active, then FP, SYNC, BP. H_TOT=sum. Vertical identical
//   in lines. hblank = x>=H_ACTIVE; hsync = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
//   vblank/vsync from y alone, so they hold for whole lines.
//  Counters, on pix_en: x==H_TOT-1 -> x=0 and y advances; y==V_TOT-1 with x wrap -> y=0.
//   pix_en low: counters, delay line, frame_count and frame_start all hold.
//  Wrap (H_TOT-1,V_TOT-1) -> (0,0): frame_count+1 (FRAME_W wrap: all-ones -> 0) and
//   frame_start=1 for exactly one clk, the clk in which (0,0) first appears.
//   frame_start is never asserted by reset.
//  Delay line: {hsync,vsync,hblank,vblank,de} decoded from the current counters, then
//   shifted through OUT_DELAY registers, one shift per enabled cycle. OUT_DELAY=0:
//   outputs are a combinational decode of the registered counters.
//  rgb: gated with the delayed de; blank_force overrides combinationally in any cycle.
//  Reset asserted mid-frame: everything clears asynchronously; frame_count returns to 0.
//  Elaboration: XW/YW too narrow for the totals, or OUT_DELAY>4, is a $error.
// TESTING
//  Defaults, pix_en=1, run 2 frames -> hsync high for 8 clks at x=376..383 (delayed 1).
//   Line period 520 clks; frame period 273000 clks; frame_count 0->1->2.
//  OUT_DELAY=3 -> de rises 3 clks after video_x returns to 0 on line y=0.
//   hblank/vsync show the same 3-clk offset.
//  pix_en toggled 1/0 each clk -> line period 1040 clks; outputs stable while pix_en=0.
//  FRAME_W=2, run 5 frames -> frame_count 1,2,3,0,1.
//   frame_start pulses 5 times, each 1 clk wide.
//  rgb_in=24'hFFFFFF: rgb=0 during blanking; rgb=FFFFFF when de=1.
//   blank_force=1 -> rgb=0 in the same clk.
//  Assert reset at x=200,y=100 -> all outputs 0 immediately.
//   After release, (0,0) appears on the first enabled clk and no frame_start pulse occurs.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle of the video timing generator: enables and RGB in, counters,
// sync/blank/de, gated RGB and frame bookkeeping out.
interface video_timing_gen_if #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int FRAME_W = 8
);
  logic               pix_en;
  logic               blank_force;
  logic [23:0]        rgb_in;
  logic [XW-1:0]      video_x;
  logic [YW-1:0]      video_y;
  logic               hsync;
  logic               vsync;
  logic               hblank;
  logic               vblank;
  logic               de;
  logic [23:0]        rgb;
  logic [FRAME_W-1:0] frame_count;
  logic               frame_start;

  modport master (
    input  pix_en, blank_force, rgb_in,
    output video_x, video_y, hsync, vsync, hblank, vblank, de, rgb,
           frame_count, frame_start
  );

  modport slave (
    output pix_en, blank_force, rgb_in,
    input  video_x, video_y, hsync, vsync, hblank, vblank, de, rgb,
           frame_count, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator: pixel/line counters, sync/blank/de decode
// aligned to the RGB pipeline by OUT_DELAY enabled stages, RGB gating, frame counter.
module video_timing_gen #(
  parameter int H_ACTIVE  = 360,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 8,
  parameter int H_BP      = 136,
  parameter int V_ACTIVE  = 360,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 159,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int OUT_DELAY = 1,
  parameter int FRAME_W   = 8
) (
  input  logic                clk_vid_32_768,
  input  logic                reset,
  video_timing_gen_if.master  vif
);
  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  generate
    if ((H_TOT - 1) >= (1 << XW) || (V_TOT - 1) >= (1 << YW)) begin : g_bad_width
      $error("video_timing_gen: XW/YW too narrow for H_TOT=%0d V_TOT=%0d", H_TOT, V_TOT);
    end
    if (OUT_DELAY < 0 || OUT_DELAY > 4) begin : g_bad_delay
      $error("video_timing_gen: OUT_DELAY=%0d outside 0..4", OUT_DELAY);
    end
  endgenerate

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
    logic de;
  } tim_t;

  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  logic               fs_q, fs_d;
  logic               x_last, y_last;
  tim_t               tap_d, tim_out;

  assign x_last = (int'(x_q) == H_TOT - 1);
  assign y_last = (int'(y_q) == V_TOT - 1);

  // frame_start defaults low so the pulse is one clk wide even if pix_en drops next
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    fs_d = 1'b0;
    if (vif.pix_en) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d  = '0;
          fc_d = fc_q + 1'b1;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_vid_32_768 or posedge reset) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
      fs_q <= fs_d;
    end
  end

  // Compare as int so a sync end equal to 2**XW cannot truncate
  always_comb begin
    tap_d        = '0;
    tap_d.hblank = int'(x_q) >= H_ACTIVE;
    tap_d.vblank = int'(y_q) >= V_ACTIVE;
    tap_d.hsync  = (int'(x_q) >= HS_BEG) && (int'(x_q) < HS_END);
    tap_d.vsync  = (int'(y_q) >= VS_BEG) && (int'(y_q) < VS_END);
    tap_d.de     = !tap_d.hblank && !tap_d.vblank;
  end

  generate
    if (OUT_DELAY == 0) begin : g_nodly
      assign tim_out = tap_d;
    end else begin : g_dly
      tim_t [OUT_DELAY-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d = pipe_q;
        if (vif.pix_en) begin
          pipe_d[0] = tap_d;
          for (int i = 1; i < OUT_DELAY; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk_vid_32_768 or posedge reset) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= pipe_d;
      end

      assign tim_out = pipe_q[OUT_DELAY-1];
    end
  endgenerate

  assign vif.video_x     = x_q;
  assign vif.video_y     = y_q;
  assign vif.hsync       = tim_out.hsync;
  assign vif.vsync       = tim_out.vsync;
  assign vif.hblank      = tim_out.hblank;
  assign vif.vblank      = tim_out.vblank;
  assign vif.de          = tim_out.de;
  assign vif.frame_count = fc_q;
  assign vif.frame_start = fs_q;
  assign vif.rgb         = (vif.blank_force || !tim_out.de) ? 24'h0 : vif.rgb_in;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken 16x8 raster, OUT_DELAY=3, FRAME_W=2.
module tb_video_timing_gen;
  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;   // H_TOT 16, hsync x=10..12
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;   // V_TOT 8,  vsync y=5..6
  localparam int H_TOT = 16, V_TOT = 8;
  localparam int XW = 5, YW = 5, OUT_DELAY = 3, FRAME_W = 2;

  logic gclk = 1'b0;
  logic rst;
  always #5 gclk = ~gclk;

  video_timing_gen_if #(.XW(XW), .YW(YW), .FRAME_W(FRAME_W)) vif ();

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .XW(XW), .YW(YW), .OUT_DELAY(OUT_DELAY), .FRAME_W(FRAME_W)
  ) dut (
    .clk_vid_32_768(gclk),
    .reset(rst),
    .vif(vif)
  );

  int n_chk = 0, n_fail = 0;
  int ex, ey;
  logic [4:0] hist[3];
  logic [1:0] efc;
  logic       efs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] dec(input int x, input int y);
    logic hs, vs, hb, vb;
    hb = x >= 8;
    vb = y >= 4;
    hs = (x >= 10) && (x < 13);
    vs = (y >= 5) && (y < 7);
    return {hs, vs, hb, vb, !hb && !vb};
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({vif.video_x, vif.video_y, vif.hsync, vif.vsync, vif.hblank, vif.vblank,
                vif.de, vif.frame_count, vif.frame_start, vif.rgb});
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [23:0] erg;
    erg = (vif.blank_force || !hist[2][0]) ? 24'h0 : vif.rgb_in;
    return 64'({5'(ex), 5'(ey), hist[2], efc, efs, erg});
  endfunction

  task automatic model_reset();
    ex = 0; ey = 0; efc = '0; efs = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // One clock: advance the reference model, then compare every output just after the edge
  task automatic tick();
    logic en;
    en = vif.pix_en;
    @(posedge gclk);
    efs = 1'b0;
    if (en) begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = dec(ex, ey);
      if (ex == H_TOT - 1) begin
        ex = 0;
        if (ey == V_TOT - 1) begin
          ey = 0; efc = efc + 2'd1; efs = 1'b1;
        end else ey++;
      end else ex++;
    end
    #1;
    chk("cycle", dut_vec(), exp_vec());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int de_x, hb_x, hs_x, vs_y, vs_x, hs_cnt, npulse, first_fs, fs_gap, x0a, x0b, found, cnt;
    logic [1:0] fcs[5];
    logic [XW-1:0] px;
    de_x = -1; hb_x = -1; hs_x = -1; vs_y = -1; vs_x = -1;
    hs_cnt = 0; npulse = 0; first_fs = -1; fs_gap = -1; x0a = -1; x0b = -1;
    for (int i = 0; i < 5; i++) fcs[i] = '0;

    vif.pix_en = 1'b1; vif.blank_force = 1'b0; vif.rgb_in = 24'hFFFFFF;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #11;
    chk("rst_xy",     64'({vif.video_x, vif.video_y}), 64'h0);
    chk("rst_sync",   64'({vif.hsync, vif.vsync, vif.hblank, vif.vblank, vif.de}), 64'h0);
    chk("rst_frame",  64'({vif.frame_count, vif.frame_start}), 64'h0);
    chk("rst_rgb",    64'(vif.rgb), 64'h0);
    @(negedge gclk) rst = 1'b0;
    #1 chk("first_pix", 64'({vif.video_x, vif.video_y}), 64'h0);

    // Five frames at full rate
    for (int i = 0; i < 5 * H_TOT * V_TOT; i++) begin
      tick();
      if (vif.de && de_x < 0) de_x = int'(vif.video_x);
      if (vif.hblank && hb_x < 0) hb_x = int'(vif.video_x);
      if (vif.hsync && hs_x < 0) hs_x = int'(vif.video_x);
      if (vif.vsync && vs_y < 0) begin vs_y = int'(vif.video_y); vs_x = int'(vif.video_x); end
      if (vif.hsync && vif.video_y == 5'd1 && npulse == 0) hs_cnt++;
      if (vif.video_x == 5'd0 && x0a < 0) x0a = i;
      else if (vif.video_x == 5'd0 && x0b < 0) x0b = i;
      if (vif.frame_start) begin
        if (npulse < 5) fcs[npulse] = vif.frame_count;
        if (npulse == 0) first_fs = i;
        if (npulse == 1) fs_gap = i - first_fs;
        npulse++;
      end
    end
    chk("de_rise_x",     64'(de_x), 64'd3);
    chk("hblank_rise_x", 64'(hb_x), 64'd11);
    chk("hsync_rise_x",  64'(hs_x), 64'd13);
    chk("vsync_rise_yx", 64'({vs_y[7:0], vs_x[7:0]}), 64'h0503);
    chk("hsync_width",   64'(hs_cnt), 64'd3);
    chk("line_period",   64'(x0b - x0a), 64'd16);
    chk("frame_period",  64'(fs_gap), 64'd128);
    chk("fs_pulses",     64'(npulse), 64'd5);
    chk("fc_seq",        64'({fcs[0], fcs[1], fcs[2], fcs[3], fcs[4]}), 64'b01_10_11_00_01);

    // RGB gating and blank_force override
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin tick(); found = int'(vif.de); end
    chk("de_found", 64'(found), 64'd1);
    chk("rgb_pass", 64'(vif.rgb), 64'hFFFFFF);
    vif.rgb_in = 24'h123456;
    #1 chk("rgb_pass2", 64'(vif.rgb), 64'h123456);
    vif.blank_force = 1'b1;
    #1 chk("bf_same_clk", 64'(vif.rgb), 64'h0);
    tick();
    vif.blank_force = 1'b0;
    vif.rgb_in = 24'hFFFFFF;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin tick(); found = int'(vif.hblank); end
    chk("hblank_found", 64'(found), 64'd1);
    chk("rgb_blank", 64'(vif.rgb), 64'h0);

    // Half-rate pixel enable doubles the line period
    x0a = -1; x0b = -1; px = vif.video_x;
    for (int i = 0; i < 100; i++) begin
      vif.pix_en = i[0];
      tick();
      if (vif.video_x == 5'd0 && px != 5'd0) begin
        if (x0a < 0) x0a = i; else if (x0b < 0) x0b = i;
      end
      px = vif.video_x;
    end
    chk("half_rate_line", 64'(x0b - x0a), 64'd32);
    vif.pix_en = 1'b1;

    // Asynchronous reset mid-frame
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = int'(vif.video_x == 5'd5 && vif.video_y == 5'd3);
    end
    chk("mid_found", 64'(found), 64'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("rst_async", dut_vec(), 64'h0);
    @(negedge gclk) rst = 1'b0;
    #1 chk("rel_xyfs", 64'({vif.video_x, vif.video_y, vif.frame_start}), 64'h0);
    cnt = 0;
    for (int i = 0; i < H_TOT * V_TOT - 1; i++) begin
      tick();
      if (vif.frame_start) cnt++;
    end
    chk("no_fs_after_rst", 64'(cnt), 64'd0);
    tick();
    chk("fs_after_frame", 64'({vif.frame_start, vif.frame_count}), 64'b1_01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
